// File: rtl/i2s_receiver.sv
// I2S slave receiver: synchronizes bclk/lrclk/data into the clk domain and
// emits stereo sample pairs, flagging words whose bit count is wrong.
module i2s_receiver #(
  parameter int SAMPLE_BITS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i2s_bclk,
  input  logic                   i2s_lrclk,
  input  logic                   i2s_data,
  output logic [SAMPLE_BITS-1:0] left_o,
  output logic [SAMPLE_BITS-1:0] right_o,
  output logic                   sample_valid,
  output logic                   frame_error
);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_e;

  logic                   bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic                   lrclk_s1_q, lrclk_s2_q;
  logic                   data_s1_q, data_s2_q;

  state_e                 state_q, state_d;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  logic [SAMPLE_BITS-1:0] hold_q, hold_d;
  logic [SAMPLE_BITS-1:0] left_q, left_d;
  logic [SAMPLE_BITS-1:0] right_q, right_d;
  logic [5:0]             bit_cnt_q, bit_cnt_d;
  logic                   lrclk_prev_q, lrclk_prev_d;
  logic                   left_held_q, left_held_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;

  logic                   rise_evt;
  logic                   boundary;
  logic                   word_ok;

  assign rise_evt = bclk_s2_q & ~bclk_s3_q;
  assign boundary = rise_evt & (lrclk_s2_q != lrclk_prev_q);
  // The boundary bit itself completes the word, hence the +1.
  assign word_ok  = (({1'b0, bit_cnt_q} + 7'd1) == 7'(SAMPLE_BITS));

  // Input synchronizers and the extra bclk stage for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_s1_q  <= 1'b0;
      bclk_s2_q  <= 1'b0;
      bclk_s3_q  <= 1'b0;
      lrclk_s1_q <= 1'b0;
      lrclk_s2_q <= 1'b0;
      data_s1_q  <= 1'b0;
      data_s2_q  <= 1'b0;
    end else begin
      bclk_s1_q  <= i2s_bclk;
      bclk_s2_q  <= bclk_s1_q;
      bclk_s3_q  <= bclk_s2_q;
      lrclk_s1_q <= i2s_lrclk;
      lrclk_s2_q <= lrclk_s1_q;
      data_s1_q  <= i2s_data;
      data_s2_q  <= data_s1_q;
    end
  end

  // Receiver state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HUNT;
      shift_q      <= '0;
      hold_q       <= '0;
      left_q       <= '0;
      right_q      <= '0;
      bit_cnt_q    <= 6'd0;
      lrclk_prev_q <= 1'b0;
      left_held_q  <= 1'b0;
      valid_q      <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      left_q       <= left_d;
      right_q      <= right_d;
      bit_cnt_q    <= bit_cnt_d;
      lrclk_prev_q <= lrclk_prev_d;
      left_held_q  <= left_held_d;
      valid_q      <= valid_d;
      ferr_q       <= ferr_d;
    end
  end

  // Next-state logic: everything advances only on a bclk rising event.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    left_d       = left_q;
    right_d      = right_q;
    bit_cnt_d    = bit_cnt_q;
    lrclk_prev_d = lrclk_prev_q;
    left_held_d  = left_held_q;
    valid_d      = 1'b0;
    ferr_d       = 1'b0;

    if (rise_evt) begin
      shift_d      = {shift_q[SAMPLE_BITS-2:0], data_s2_q};
      lrclk_prev_d = lrclk_s2_q;
      if (boundary) begin
        bit_cnt_d = 6'd0;
        case (state_q)
          HUNT: state_d = RECV;
          RECV: begin
            if (!word_ok) begin
              ferr_d      = 1'b1;
              left_held_d = 1'b0;
            end else if (!lrclk_prev_q) begin
              hold_d      = shift_d;
              left_held_d = 1'b1;
            end else if (left_held_q) begin
              left_d      = hold_q;
              right_d     = shift_d;
              valid_d     = 1'b1;
              left_held_d = 1'b0;
            end else begin
              left_held_d = 1'b0;
            end
          end
          default: state_d = HUNT;
        endcase
      end else if (bit_cnt_q != 6'd63) begin
        bit_cnt_d = bit_cnt_q + 6'd1;
      end else begin
        bit_cnt_d = bit_cnt_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  assign left_o       = left_q;
  assign right_o      = right_q;
  assign sample_valid = valid_q;
  assign frame_error  = ferr_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: drives I2S slots from a bit queue and
// compares every output pair against hand-listed expected pairs.
module tb_i2s_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i2s_bclk = 1'b0;
  logic        i2s_lrclk = 1'b0;
  logic        i2s_data = 1'b0;
  logic [15:0] left_o, right_o;
  logic        sample_valid, frame_error;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_err   = 0;
  int cyc     = 0;
  int rise_cyc = 0;

  bit          lr_q[$];
  bit          d_q[$];
  logic [15:0] exp_l[$];
  logic [15:0] exp_r[$];

  i2s_receiver #(.SAMPLE_BITS(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_data     (i2s_data),
    .left_o       (left_o),
    .right_o      (right_o),
    .sample_valid (sample_valid),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: every pulse is checked for latency and content.
  always @(negedge clk) begin
    if (sample_valid) begin
      n_valid++;
      check_eq("valid_latency", cyc - rise_cyc, 3);
      check_eq("valid_expected", exp_l.size() > 0, 1);
      if (exp_l.size() > 0) begin
        check_eq("left_o", left_o, exp_l.pop_front());
        check_eq("right_o", right_o, exp_r.pop_front());
      end
    end
    if (frame_error) begin
      n_err++;
      check_eq("ferr_latency", cyc - rise_cyc, 3);
    end
    if (sample_valid && frame_error) check_eq("valid_ferr_excl", 2, 1);
  end

  task automatic add_slot(input bit lr, input logic [15:0] w, input int n);
    for (int b = n - 1; b >= 0; b--) begin
      lr_q.push_back(lr);
      d_q.push_back(w[b]);
    end
  endtask

  task automatic add_frame(input logic [15:0] l, input logic [15:0] r);
    add_slot(1'b0, l, 16);
    add_slot(1'b1, r, 16);
  endtask

  task automatic expect_pair(input logic [15:0] l, input logic [15:0] r);
    exp_l.push_back(l);
    exp_r.push_back(r);
  endtask

  // Data lags lrclk by one bclk: each word's LSB goes out in the next slot.
  task automatic send_stream(input int half, input int rst_at);
    bit last_lr;
    last_lr = lr_q[lr_q.size()-1];
    add_slot(~last_lr, 16'h0000, 1);
    for (int i = 0; i < lr_q.size(); i++) begin
      @(negedge clk);
      i2s_bclk  = 1'b0;
      i2s_lrclk = lr_q[i];
      i2s_data  = (i == 0) ? 1'b0 : d_q[i-1];
      if (i == rst_at) begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_eq("midword_rst_left", left_o, 0);
        check_eq("midword_rst_right", right_o, 0);
      end
      repeat (half) @(negedge clk);
      i2s_bclk = 1'b1;
      rise_cyc = cyc;
      repeat (half - 1) @(negedge clk);
    end
    @(negedge clk);
    i2s_bclk = 1'b0;
    repeat (8) @(negedge clk);
    lr_q.delete();
    d_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    i2s_bclk  = 1'b0;
    i2s_lrclk = 1'b0;
    i2s_data  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_valid = 0;
    n_err   = 0;
  endtask

  task automatic end_scenario(input string tag, input int nv, input int ne,
                              input logic [15:0] l, input logic [15:0] r);
    check_eq({tag, "_valid_cnt"}, n_valid, nv);
    check_eq({tag, "_ferr_cnt"}, n_err, ne);
    check_eq({tag, "_left"}, left_o, l);
    check_eq({tag, "_right"}, right_o, r);
    check_eq({tag, "_pending"}, exp_l.size(), 0);
  endtask

  initial begin
    // Reset state, checked while reset is held and just after release.
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_left", left_o, 0);
    check_eq("rst_right", right_o, 0);
    check_eq("rst_valid", sample_valid, 0);
    check_eq("rst_ferr", frame_error, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("post_rst_left", left_o, 0);

    // Three frames at clk/16: first lost in HUNT.
    do_reset();
    for (int f = 0; f < 3; f++) add_frame(16'hA5C3, 16'h1234);
    expect_pair(16'hA5C3, 16'h1234);
    expect_pair(16'hA5C3, 16'h1234);
    send_stream(8, -1);
    end_scenario("basic", 2, 0, 16'hA5C3, 16'h1234);

    // Short 15-bit right slot after lock.
    do_reset();
    add_frame(16'h1111, 16'h2222);
    add_frame(16'h1111, 16'h2222);
    add_slot(1'b0, 16'h3333, 16);
    add_slot(1'b1, 16'h7777, 15);
    add_frame(16'h4444, 16'h5555);
    expect_pair(16'h1111, 16'h2222);
    expect_pair(16'h4444, 16'h5555);
    send_stream(8, -1);
    end_scenario("short", 2, 1, 16'h4444, 16'h5555);

    // Stream begins mid right slot: partial slot is a bad word after HUNT.
    do_reset();
    add_slot(1'b1, 16'h0055, 7);
    add_frame(16'hAAAA, 16'h5555);
    add_frame(16'h0F0F, 16'hF0F0);
    expect_pair(16'hAAAA, 16'h5555);
    expect_pair(16'h0F0F, 16'hF0F0);
    send_stream(8, -1);
    end_scenario("midstart", 2, 1, 16'h0F0F, 16'hF0F0);

    // Reset mid left word of frame 7; frame 7 is lost.
    do_reset();
    for (int f = 1; f <= 9; f++) begin
      add_frame(16'h1000 + 16'(f), 16'h2000 + 16'(f));
      if ((f >= 2 && f <= 6) || f >= 8) expect_pair(16'h1000 + 16'(f), 16'h2000 + 16'(f));
    end
    send_stream(8, 200);
    end_scenario("midrst", 7, 0, 16'h1009, 16'h2009);

    // Minimum ratio clk/4, alternating patterns.
    do_reset();
    add_frame(16'h8001, 16'h7FFE);
    add_frame(16'h7FFE, 16'h8001);
    add_frame(16'h8001, 16'h7FFE);
    add_frame(16'h7FFE, 16'h8001);
    expect_pair(16'h7FFE, 16'h8001);
    expect_pair(16'h8001, 16'h7FFE);
    expect_pair(16'h7FFE, 16'h8001);
    send_stream(2, -1);
    end_scenario("fast", 3, 0, 16'h7FFE, 16'h8001);

    // lrclk and data toggle with bclk held low: nothing may happen.
    n_valid = 0;
    n_err   = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      i2s_lrclk = ~i2s_lrclk;
      i2s_data  = ~i2s_data;
      repeat (3) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    end_scenario("static_bclk", 0, 0, 16'h7FFE, 16'h8001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
